cdc_handshake_tx: RTL and testbench

- Source-domain end of a two-phase (toggle) req/ack CDC handshake carrying a WIDTH-bit word to another clock domain.
- Accepts a word on a valid/ready port and holds it stable on xfer_data.
- Toggles req_toggle and waits for the destination's ack_toggle. ack_toggle is brought into this domain through an internal N_STAGE flop synchronizer.
- Pairs with the destination-side receiver, which synchronizes req_toggle, captures xfer_data and returns ack_toggle.

---
 rtl/cdc_pkg.sv | 12 +
 rtl/cdc_sync_bit_rstn.sv | 30 +++
 rtl/cdc_handshake_tx.sv | 98 +++++++++
 tb/tb_cdc_handshake_tx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types and constants for the toggle req/ack CDC handshake blocks.
// Contents: hs_tx_state_t source FSM states, CDC_MIN_STAGES synchronizer floor.
package cdc_pkg;

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } hs_tx_state_t;

    localparam int CDC_MIN_STAGES = 2;

endpackage

// File: rtl/cdc_sync_bit_rstn.sv
// Single-bit N_STAGE flop synchronizer with synchronous active-low reset.
// Ports: clk, rst_n, d (async input), q (synchronized output).
module cdc_sync_bit_rstn
    import cdc_pkg::*;
#(
    parameter int N_STAGE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (N_STAGE < CDC_MIN_STAGES) begin : g_depth_chk
        $error("cdc_sync_bit_rstn: N_STAGE below CDC_MIN_STAGES");
    end

    (* ASYNC_REG = "TRUE" *) logic [N_STAGE-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N_STAGE-2:0], d};
        end
    end

    assign q = sync_q[N_STAGE-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source end of a two-phase toggle CDC handshake carrying one WIDTH-bit word.
// Ports: clk, rst_n; s_data/s_valid/s_ready upstream; xfer_data/req_toggle
// to destination; ack_toggle from destination; busy, done, xfer_count,
// err_spurious status.
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N_STAGE = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] xfer_data,
    output logic             req_toggle,
    input  logic             ack_toggle,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] xfer_count,
    output logic             err_spurious
);

    hs_tx_state_t state_q;
    hs_tx_state_t state_d;
    logic         ack_sync;
    logic         ack_match;
    logic         accept;
    logic         complete;
    logic         spurious;

    cdc_sync_bit_rstn #(
        .N_STAGE(N_STAGE)
    ) u_ack_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (ack_toggle),
        .q    (ack_sync)
    );

    // Destination has caught up when its ack phase equals our req phase.
    assign ack_match = (ack_sync == req_toggle);

    always_comb begin
        state_d  = state_q;
        s_ready  = 1'b0;
        busy     = 1'b0;
        accept   = 1'b0;
        complete = 1'b0;
        spurious = 1'b0;
        unique case (state_q)
            IDLE: begin
                s_ready  = 1'b1;
                accept   = s_valid;
                spurious = !ack_match;
                if (s_valid) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                busy     = 1'b1;
                complete = ack_match;
                if (ack_match) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            xfer_data    <= '0;
            req_toggle   <= 1'b0;
            done         <= 1'b0;
            xfer_count   <= '0;
            err_spurious <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= complete;
            // Data and req flip on the same edge so data is never newer.
            if (accept) begin
                xfer_data  <= s_data;
                req_toggle <= ~req_toggle;
            end
            if (complete) begin
                xfer_count <= xfer_count + CNT_W'(1);
            end
            if (spurious) begin
                err_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx with a scoreboard and dest model.
// Ports: none (top-level testbench).
module tb_cdc_handshake_tx;

    localparam int WIDTH   = 32;
    localparam int N_STAGE = 2;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] xfer_data;
    logic             req_toggle;
    logic             ack_toggle = 1'b0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] xfer_count;
    logic             err_spurious;

    cdc_handshake_tx #(
        .WIDTH  (WIDTH),
        .N_STAGE(N_STAGE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .xfer_data   (xfer_data),
        .req_toggle  (req_toggle),
        .ack_toggle  (ack_toggle),
        .busy        (busy),
        .done        (done),
        .xfer_count  (xfer_count),
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             req;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ack_at = 0;
    logic req_m = 1'b0;
    int   cnt_m = 0;
    bit   dest_en = 1'b0;
    bit   fix_lat = 1'b0;
    int   lat = 5;
    int   wait_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Destination model: mirrors req back as ack after a few cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (dest_en && rst_n && req_toggle != ack_toggle) begin
                wait_n++;
                if (wait_n >= lat) begin
                    ack_toggle = req_toggle;
                    ack_at = cyc;
                    wait_n = 0;
                    lat = fix_lat ? 5 : int'($urandom_range(1, 6));
                end
            end else begin
                wait_n = 0;
            end
        end
    end

    // Monitor: payload stable while busy; each done retires one entry.
    initial begin
        bit   done_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_prev = 1'b0;
            end else begin
                if (busy) begin
                    if (q.size() == 0) chk("busy_no_entry", 32'(busy), 0);
                    else chk("data_stable", xfer_data, q[0].data);
                end
                if (done) begin
                    if (done_prev) chk("done_width", 32'(done_prev), 0);
                    if (q.size() == 0) begin
                        chk("done_no_entry", 32'(done), 0);
                    end else begin
                        e = q.pop_front();
                        chk("done_count", 32'(xfer_count), 32'(e.cnt));
                        chk("done_req", 32'(req_toggle), 32'(e.req));
                        chk("done_latency", cyc - ack_at, N_STAGE + 1);
                        chk("done_ready", 32'(s_ready), 1);
                    end
                end
                done_prev = done;
            end
        end
    end

    task automatic model_reset();
        q.delete();
        req_m = 1'b0;
        cnt_m = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_valid = 1'b0;
        ack_toggle = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input bit hold,
                        input bit b2b);
        int n = 0;
        s_data = d;
        s_valid = 1'b1;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            chk("accept_timeout", 32'(s_ready), 1);
            s_valid = 1'b0;
            return;
        end
        if (b2b) chk("b2b_on_done", 32'(done), 1);
        req_m = ~req_m;
        cnt_m++;
        q.push_back('{d, req_m, CNT_W'(cnt_m)});
        @(negedge clk);
        chk("acc_data", xfer_data, d);
        chk("acc_req", 32'(req_toggle), 32'(req_m));
        chk("acc_ready", 32'(s_ready), 0);
        if (!hold) s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy || q.size() != 0) chk("idle_timeout", 32'(busy), 0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_ready", 32'(s_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req", 32'(req_toggle), 0);
        chk("rst_count", 32'(xfer_count), 0);
        chk("rst_err", 32'(err_spurious), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_data", xfer_data, 0);

        // Single transfer
        dest_en = 1'b1;
        send(32'hDEADBEEF, 1'b0, 1'b0);
        wait_idle();
        chk("single_count", 32'(xfer_count), 1);

        // Back-to-back, fixed 5-cycle destination
        fix_lat = 1'b1;
        lat = 5;
        for (int i = 1; i <= 4; i++) begin
            send(WIDTH'(i), 1'b0, i > 1);
        end
        wait_idle();
        chk("b2b_count", 32'(xfer_count), 5);
        chk("b2b_req", 32'(req_toggle), 1);
        fix_lat = 1'b0;

        // Backpressure: upstream changes word while we are busy
        send(32'hA5, 1'b1, 1'b0);
        s_data = 32'h5A;
        @(negedge clk);
        chk("bp_hold", xfer_data, 32'hA5);
        send(32'h5A, 1'b0, 1'b1);
        wait_idle();
        chk("bp_second", xfer_data, 32'h5A);

        // Spurious ack in IDLE
        dest_en = 1'b0;
        @(negedge clk);
        ack_toggle = ~ack_toggle;
        repeat (2) @(negedge clk);
        chk("spur_early", 32'(err_spurious), 0);
        @(negedge clk);
        chk("spur_set", 32'(err_spurious), 1);
        chk("spur_ready", 32'(s_ready), 1);
        chk("spur_busy", 32'(busy), 0);
        ack_toggle = ~ack_toggle;
        repeat (4) @(negedge clk);
        dest_en = 1'b1;
        send($urandom, 1'b0, 1'b0);
        wait_idle();
        chk("spur_sticky", 32'(err_spurious), 1);
        do_reset();
        chk("spur_clear", 32'(err_spurious), 0);

        // Counter wrap: 16 random transfers
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send($urandom, 1'b0, 1'b0);
        end
        wait_idle();
        chk("wrap_count", 32'(xfer_count), 0);
        chk("wrap_err", 32'(err_spurious), 0);

        // Reset during WAIT_ACK
        dest_en = 1'b0;
        send($urandom, 1'b0, 1'b0);
        @(negedge clk);
        chk("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        ack_toggle = 1'b0;
        @(negedge clk);
        chk("mid_ready", 32'(s_ready), 1);
        chk("mid_req", 32'(req_toggle), 0);
        chk("mid_busy_clr", 32'(busy), 0);
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mid_no_done", 32'(done), 0);
        end
        chk("mid_err", 32'(err_spurious), 0);
        chk("mid_count", 32'(xfer_count), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
